// File: rtl/vx_commit_arb.sv
// rtl/vx_commit_arb.sv - commit arbiter: round-robin writeback grant plus retired-thread counting
module vx_commit_arb #(
    parameter int NUM_CH      = 5,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int CNT_W       = 64,
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int SIZE_W     = $clog2(NUM_CH*NUM_THREADS+1),
    localparam int PTR_W      = $clog2(NUM_CH)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_CH-1:0]                 i_cmt_valid,
    output logic [NUM_CH-1:0]                 o_cmt_ready,
    input  logic [NUM_CH-1:0]                 i_cmt_wb,
    input  logic [NUM_CH*NW_BITS-1:0]         i_cmt_wid,
    input  logic [NUM_CH*NUM_THREADS-1:0]     i_cmt_tmask,
    input  logic [NUM_CH*5-1:0]               i_cmt_rd,
    input  logic [NUM_CH*NUM_THREADS*32-1:0]  i_cmt_data,
    output logic                              o_wb_valid,
    input  logic                              i_wb_ready,
    output logic [NW_BITS-1:0]                o_wb_wid,
    output logic [NUM_THREADS-1:0]            o_wb_tmask,
    output logic [4:0]                        o_wb_rd,
    output logic [NUM_THREADS*32-1:0]         o_wb_data,
    output logic                              o_csr_valid,
    output logic [SIZE_W-1:0]                 o_csr_commit_size,
    output logic [CNT_W-1:0]                  o_instret
);

    logic                       r_wb_valid;
    logic [NW_BITS-1:0]         r_wb_wid;
    logic [NUM_THREADS-1:0]     r_wb_tmask;
    logic [4:0]                 r_wb_rd;
    logic [NUM_THREADS*32-1:0]  r_wb_data;
    logic [PTR_W-1:0]           r_rr_ptr;
    logic                       r_csr_valid;
    logic [SIZE_W-1:0]          r_csr_size;
    logic [CNT_W-1:0]           r_instret;

    logic [NUM_CH-1:0]          w_req;
    logic                       w_gnt_found;
    logic [PTR_W-1:0]           w_gnt_idx;
    logic                       w_stage_free;
    logic                       w_gnt_fire;
    logic [NUM_CH-1:0]          w_fire;
    logic [SIZE_W-1:0]          w_size;
    logic [PTR_W-1:0]           w_ptr_next;

    assign w_req        = i_cmt_valid & i_cmt_wb;
    assign w_stage_free = !r_wb_valid || i_wb_ready;
    assign w_gnt_fire   = w_gnt_found && w_stage_free;

    // First requesting writeback channel at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = (int'(r_rr_ptr) + off) % NUM_CH;
            if (!w_gnt_found && w_req[idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        o_cmt_ready = ~i_cmt_wb;
        if (w_gnt_fire) begin
            o_cmt_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_fire = i_cmt_valid & o_cmt_ready;

    always_comb begin
        w_size = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_fire[i]) begin
                w_size = w_size + SIZE_W'($countones(i_cmt_tmask[i*NUM_THREADS +: NUM_THREADS]));
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == PTR_W'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wb_valid  <= 1'b0;
            r_wb_wid    <= '0;
            r_wb_tmask  <= '0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_rr_ptr    <= '0;
            r_csr_valid <= 1'b0;
            r_csr_size  <= '0;
            r_instret   <= '0;
        end else begin
            if (w_gnt_fire) begin
                r_wb_valid <= 1'b1;
                r_wb_wid   <= i_cmt_wid[w_gnt_idx*NW_BITS +: NW_BITS];
                r_wb_tmask <= i_cmt_tmask[w_gnt_idx*NUM_THREADS +: NUM_THREADS];
                r_wb_rd    <= i_cmt_rd[w_gnt_idx*5 +: 5];
                r_wb_data  <= i_cmt_data[w_gnt_idx*NUM_THREADS*32 +: NUM_THREADS*32];
                r_rr_ptr   <= w_ptr_next;
            end else if (i_wb_ready) begin
                r_wb_valid <= 1'b0;
            end
            r_csr_valid <= |w_fire;
            r_csr_size  <= w_size;
            if (r_csr_valid) begin
                r_instret <= r_instret + CNT_W'(r_csr_size);
            end
        end
    end

    assign o_wb_valid        = r_wb_valid;
    assign o_wb_wid          = r_wb_wid;
    assign o_wb_tmask        = r_wb_tmask;
    assign o_wb_rd           = r_wb_rd;
    assign o_wb_data         = r_wb_data;
    assign o_csr_valid       = r_csr_valid;
    assign o_csr_commit_size = r_csr_size;
    assign o_instret         = r_instret;

endmodule

// File: tb/tb_vx_commit_arb.sv
// tb/tb_vx_commit_arb.sv - scoreboard bench for vx_commit_arb with a spec-level reference model
module tb_vx_commit_arb;
    localparam int NCH = 5;
    localparam int NT  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   cmt_valid, cmt_wb, cmt_ready;
    logic [9:0]   cmt_wid;
    logic [19:0]  cmt_tmask;
    logic [24:0]  cmt_rd;
    logic [639:0] cmt_data;
    logic         wb_valid, wb_ready;
    logic [1:0]   wb_wid;
    logic [3:0]   wb_tmask;
    logic [4:0]   wb_rd;
    logic [127:0] wb_data;
    logic         csr_valid;
    logic [4:0]   csr_size;
    logic [7:0]   instret;

    always #5 clk = ~clk;

    vx_commit_arb #(.NUM_CH(NCH), .NUM_THREADS(NT), .NUM_WARPS(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_cmt_valid(cmt_valid), .o_cmt_ready(cmt_ready), .i_cmt_wb(cmt_wb),
        .i_cmt_wid(cmt_wid), .i_cmt_tmask(cmt_tmask), .i_cmt_rd(cmt_rd), .i_cmt_data(cmt_data),
        .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_wid(wb_wid), .o_wb_tmask(wb_tmask),
        .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .o_csr_valid(csr_valid), .o_csr_commit_size(csr_size), .o_instret(instret)
    );

    typedef struct packed {
        logic [1:0]   wid;
        logic [3:0]   tm;
        logic [4:0]   rd;
        logic [127:0] data;
    } wb_t;

    wb_t        exp_wb[$];
    int         exp_csr[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         m_ptr = 0;
    logic       m_wb_valid = 1'b0;
    logic [7:0] mon_instret = 8'd0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_payload();
        cmt_wid   = 10'($urandom);
        cmt_tmask = 20'($urandom);
        cmt_rd    = 25'($urandom);
        for (int w = 0; w < 20; w++) cmt_data[w*32 +: 32] = $urandom;
    endtask

    task automatic set_rd_idx();
        for (int i = 0; i < NCH; i++) cmt_rd[i*5 +: 5] = 5'(i);
    endtask

    // Drive one cycle starting just after a rising edge; predicts accepts from the arbitration rules.
    task automatic step(input logic [4:0] v, input logic [4:0] wb, input logic rdy);
        logic       free;
        int         k;
        int         c;
        int         size;
        logic [4:0] exp_rdy;
        logic [4:0] fires;
        wb_t        item;
        cmt_valid = v;
        cmt_wb    = wb;
        wb_ready  = rdy;
        #1;
        free = !m_wb_valid || rdy;
        k = -1;
        for (int off = 0; off < NCH; off++) begin
            c = (m_ptr + off) % NCH;
            if (k < 0 && v[c] && wb[c]) k = c;
        end
        exp_rdy = ~wb;
        if (k >= 0 && free) exp_rdy[k] = 1'b1;
        chk("cmt_ready", 128'(cmt_ready), 128'(exp_rdy));
        fires = v & exp_rdy;
        size = 0;
        for (int i = 0; i < NCH; i++)
            if (fires[i]) size += $countones(cmt_tmask[i*4 +: 4]);
        if (|fires) exp_csr.push_back(size);
        if (k >= 0 && free) begin
            item.wid  = cmt_wid[k*2 +: 2];
            item.tm   = cmt_tmask[k*4 +: 4];
            item.rd   = cmt_rd[k*5 +: 5];
            item.data = cmt_data[k*128 +: 128];
            exp_wb.push_back(item);
            m_ptr      = (k + 1) % NCH;
            m_wb_valid = 1'b1;
        end else if (rdy) begin
            m_wb_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("wb_valid", 128'(wb_valid), 128'(m_wb_valid));
    endtask

    always @(negedge clk) begin
        int s;
        if (mon_en && rst_n) begin
            chk("instret", 128'(instret), 128'(mon_instret));
            if (wb_valid) begin
                if (exp_wb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: got wb_valid=1 expected no pending writeback");
                end else begin
                    chk("wb_wid", 128'(wb_wid), 128'(exp_wb[0].wid));
                    chk("wb_tmask", 128'(wb_tmask), 128'(exp_wb[0].tm));
                    chk("wb_rd", 128'(wb_rd), 128'(exp_wb[0].rd));
                    chk("wb_data", wb_data, exp_wb[0].data);
                    if (wb_ready) void'(exp_wb.pop_front());
                end
            end
            if (csr_valid) begin
                if (exp_csr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL csr_unexpected: got csr_valid=1 expected no strobe");
                end else begin
                    s = exp_csr.pop_front();
                    chk("csr_size", 128'(csr_size), 128'(s));
                    mon_instret = mon_instret + 8'(s);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wb_valid"}, 128'(wb_valid), 128'(0));
        chk({tag, "_csr_valid"}, 128'(csr_valid), 128'(0));
        chk({tag, "_csr_size"}, 128'(csr_size), 128'(0));
        chk({tag, "_instret"}, 128'(instret), 128'(0));
        chk({tag, "_wb_payload"}, 128'({wb_wid, wb_tmask, wb_rd}) | wb_data, 128'(0));
    endtask

    initial begin
        logic [127:0] d0;
        rst_n     = 1'b0;
        cmt_valid = '0;
        cmt_wb    = '0;
        wb_ready  = 1'b0;
        cmt_wid   = '0;
        cmt_tmask = '0;
        cmt_rd    = '0;
        cmt_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_ready_nowb", 128'(cmt_ready), 128'(5'h1f));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Two writeback channels competing: grants must alternate 0,2,0,2
        rand_payload();
        set_rd_idx();
        for (int n = 0; n < 6; n++) begin
            step(5'b00101, 5'b00101, 1'b1);
            chk("alt_grant", 128'(wb_rd), 128'((n % 2 == 0) ? 0 : 2));
        end

        // Back-pressure: payload holds while stalled, channel 1 locked out
        step(5'b00010, 5'b00010, 1'b1);
        d0 = wb_data;
        for (int n = 0; n < 3; n++) begin
            rand_payload();
            set_rd_idx();
            step(5'b00010, 5'b00010, 1'b0);
            chk("stall_stable", wb_data, d0);
            chk("stall_ready1", 128'(cmt_ready[1]), 128'(0));
        end
        step(5'b00010, 5'b00010, 1'b1);
        chk("release_regrant", wb_data, cmt_data[128 +: 128]);
        step(5'b00000, 5'b00000, 1'b1);

        // Non-writeback and writeback fire together
        rand_payload();
        set_rd_idx();
        cmt_tmask = 20'h00F03;
        step(5'b00101, 5'b00001, 1'b1);
        chk("mix_csr_valid", 128'(csr_valid), 128'(1));
        chk("mix_csr_size", 128'(csr_size), 128'(6));
        chk("mix_wb_rd", 128'(wb_rd), 128'(0));
        step(5'b00000, 5'b00000, 1'b1);

        // Empty thread mask still handshakes and strobes size 0
        cmt_tmask = 20'h00000;
        step(5'b01000, 5'b01000, 1'b1);
        chk("tm0_csr_valid", 128'(csr_valid), 128'(1));
        chk("tm0_csr_size", 128'(csr_size), 128'(0));
        chk("tm0_wb_valid", 128'(wb_valid), 128'(1));
        chk("tm0_wb_tmask", 128'(wb_tmask), 128'(0));
        chk("tm0_wb_rd", 128'(wb_rd), 128'(3));
        step(5'b00000, 5'b00000, 1'b1);

        for (int n = 0; n < 400; n++) begin
            rand_payload();
            step(5'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while a writeback is pending
        rand_payload();
        set_rd_idx();
        step(5'b11111, 5'b11111, 1'b1);
        chk("pre_reset_wb_valid", 128'(wb_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_wb.delete();
        exp_csr.delete();
        m_ptr       = 0;
        m_wb_valid  = 1'b0;
        mon_instret = 8'd0;
        cmt_valid   = '0;
        cmt_wb      = '0;
        #1;
        chk("reset_ready", 128'(cmt_ready), 128'(5'h1f));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmt_tmask = 20'h00000;
        step(5'b11111, 5'b11111, 1'b1);
        chk("first_grant_ch0", 128'(wb_rd), 128'(0));
        step(5'b00000, 5'b00000, 1'b1);

        // Counter wrap with an 8-bit instret: 240 + 14 = 254, then +4 -> 2
        cmt_tmask = 20'hFFFFF;
        repeat (15) step(5'b11110, 5'b00000, 1'b1);
        cmt_tmask = 20'h3FFFF;
        step(5'b11110, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        chk("instret_254", 128'(instret), 128'(254));
        cmt_tmask = 20'h000F0;
        step(5'b00010, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        chk("instret_wrap", 128'(instret), 128'(2));

        repeat (3) step(5'b00000, 5'b00000, 1'b1);
        chk("wb_queue_drained", 128'(exp_wb.size()), 128'(0));
        chk("csr_queue_drained", 128'(exp_csr.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vx_commit_arb.md
VX_COMMIT_ARB -- requirements
Module: VX_commit_arb

Interface
REQ-001 Parameter NUM_CH, default 5: number of commit source channels, legal range 2..8.
REQ-002 Parameter NUM_THREADS, default 4: threads per warp.
REQ-003 Parameter NUM_WARPS, default 4: warps per core; NW_BITS = max(1, clog2(NUM_WARPS)).
REQ-004 Parameter CNT_W, default 64: width of the retired-instruction counter.
REQ-005 Derived SIZE_W = clog2(NUM_CH*NUM_THREADS+1).
REQ-006 clk  in  1  single clock; all state on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-008 cmt_valid  in  NUM_CH  per-channel commit request.
REQ-009 cmt_ready  out  NUM_CH  per-channel accept.
REQ-010 cmt_wb  in  NUM_CH  per-channel register-writeback flag.
REQ-011 cmt_wid  in  NUM_CH*NW_BITS  per-channel warp id.
REQ-012 cmt_tmask  in  NUM_CH*NUM_THREADS  per-channel thread mask.
REQ-013 cmt_rd  in  NUM_CH*5  per-channel destination register.
REQ-014 cmt_data  in  NUM_CH*NUM_THREADS*32  per-channel result data.
REQ-015 wb_valid / wb_ready  out / in  1 / 1  writeback handshake.
REQ-016 wb_wid, wb_tmask, wb_rd, wb_data  out  NW_BITS, NUM_THREADS, 5, NUM_THREADS*32  writeback payload.
REQ-017 csr_valid  out  1  commit-count update strobe.
REQ-018 csr_commit_size  out  SIZE_W  threads retired in the strobed cycle.
REQ-019 instret  out  CNT_W  accumulated retired-thread count.

Function
REQ-020 Channel i fires when cmt_valid[i] && cmt_ready[i].
REQ-021 cmt_ready[i] SHALL be 1 whenever cmt_wb[i]=0; such commits retire without arbitration and produce no writeback.
REQ-022 Among channels with cmt_valid=1 and cmt_wb=1, exactly one SHALL be granted per cycle by round-robin, starting the search at pointer rr_ptr.
REQ-023 A granted channel's cmt_ready SHALL be 1 only if the output stage is free (!wb_valid || wb_ready); ungranted wb channels SHALL see cmt_ready=0.
REQ-024 On a grant fire at channel k, rr_ptr SHALL update to (k+1) mod NUM_CH; with no grant fire, rr_ptr SHALL hold.
REQ-025 The granted payload SHALL appear on wb_* with wb_valid=1 exactly one cycle after the fire (latency 1, one output register).
REQ-026 While wb_valid && !wb_ready, all wb_* outputs SHALL hold stable, and no wb channel may fire.
REQ-027 wb_valid SHALL drop the cycle after a wb_ready handshake that has no new grant fire; back-to-back fires SHALL sustain throughput of 1/cycle.
REQ-028 csr_commit_size SHALL equal the sum over fired channels of popcount(cmt_tmask[i]), registered with 1-cycle latency; csr_valid SHALL be the registered OR of all channel fires.
REQ-029 A fire with tmask=0 SHALL still complete its handshake and strobe csr_valid with size 0.
REQ-030 instret SHALL add csr_commit_size on every cycle where csr_valid=1, wrapping modulo 2^CNT_W without a flag.
REQ-031 Non-wb and wb fires in the same cycle SHALL all be counted in that cycle's size.

Reset
REQ-032 While reset=0: wb_valid=0, csr_valid=0, csr_commit_size=0, instret=0, rr_ptr=0, wb payload=0; cmt_ready follows REQ-021/023 combinationally.
REQ-033 Reset assertion mid-transfer SHALL discard the in-flight writeback; no commit accepted in the reset cycle SHALL be counted.

Verification
REQ-034 NUM_CH=5, NUM_THREADS=4: ch0 and ch2 wb-valid every cycle, wb_ready=1 -> grants alternate 0,2,0,2; wb_valid continuous; csr_commit_size=popcount each cycle.
REQ-035 ch1 wb-valid, wb_ready=0 for 3 cycles -> wb_* stable for 3 cycles, cmt_ready[1]=0 after first fire; release -> next grant one cycle later.
REQ-036 Store-like ch2 (wb=0, tmask=1111) and ch0 (wb=1, tmask=0011) fire together -> next cycle csr_valid=1, csr_commit_size=6; only ch0 on wb port.
REQ-037 CNT_W=8, instret driven to 254, commit of size 4 -> instret=2.
REQ-038 Assert reset with wb_valid=1 and instret=100 -> all outputs 0 asynchronously; after release, first grant goes to ch0.
REQ-039 valid with tmask=0000 on ch3 (wb=1) -> handshake completes, csr_valid=1, size 0, writeback issued with tmask 0.
